// File: rtl/reg_access_ctrl_pkg.sv
// Shared widths, state encoding and small helpers for the register access controller.
package reg_access_ctrl_pkg;

    // Architectural register index, data word and default ROB tag widths.
    localparam int REGINDEX = 5;
    localparam int DATALEN  = 32;
    localparam int ROBINDEX = 4;

    // Number of source operands looked up per request (rs1, rs2).
    localparam int NUM_OPS = 2;

    // Width of the debug stall counter.
    localparam int STALL_W = 16;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // An operand only participates in lookup/bypass when it is needed and
    // does not name x0 (which always reads as a ready zero).
    function automatic logic operand_active(input logic need,
                                            input logic [REGINDEX-1:0] idx);
        return need && (idx != '0);
    endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Decoder-side request/response handshake between the decoder and the
// register access controller.
interface reg_access_ctrl_if
    import reg_access_ctrl_pkg::*;
#(
    parameter int ROB_W = ROBINDEX
);
    // Request from decoder
    logic                dec_valid;
    logic                dec_ready;
    logic [REGINDEX-1:0] dec_rs1;
    logic [REGINDEX-1:0] dec_rs2;
    logic [REGINDEX-1:0] dec_rd;
    logic                dec_need_rs1;
    logic                dec_need_rs2;
    logic                dec_have_rd;
    logic [ROB_W-1:0]    dec_rob_tag;

    // Operand response to decoder
    logic                op_valid;
    logic                op_ready;
    logic [DATALEN-1:0]  op_rs1_val;
    logic [DATALEN-1:0]  op_rs2_val;
    logic                op_rs1_busy;
    logic                op_rs2_busy;
    logic [ROB_W-1:0]    op_rs1_tag;
    logic [ROB_W-1:0]    op_rs2_tag;

    // Decoder side
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd,
               dec_need_rs1, dec_need_rs2, dec_have_rd, dec_rob_tag,
               op_ready,
        input  dec_ready,
               op_valid, op_rs1_val, op_rs2_val,
               op_rs1_busy, op_rs2_busy, op_rs1_tag, op_rs2_tag
    );

    // Controller side
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd,
               dec_need_rs1, dec_need_rs2, dec_have_rd, dec_rob_tag,
               op_ready,
        output dec_ready,
               op_valid, op_rs1_val, op_rs2_val,
               op_rs1_busy, op_rs2_busy, op_rs1_tag, op_rs2_tag
    );

endinterface

// File: rtl/reg_access_ctrl_operand_capture.sv
// One source operand: captures the regfile lookup result and keeps watching
// the commit stream so a value produced while the request waits is picked up.
module operand_capture
    import reg_access_ctrl_pkg::*;
#(
    parameter int ROB_W = ROBINDEX
)(
    input  logic                clk,
    input  logic                rst,
    // control from the controller FSM
    input  logic                load,
    input  logic                track,
    input  logic                clear,
    // latched operand selector
    input  logic [REGINDEX-1:0] idx,
    input  logic                need,
    // regfile lookup result for idx
    input  logic [DATALEN-1:0]  rd_val,
    input  logic                rd_busy,
    input  logic [ROB_W-1:0]    rd_tag,
    // commit stream
    input  logic                cmt_en,
    input  logic [REGINDEX-1:0] cmt_idx,
    input  logic [ROB_W-1:0]    cmt_tag,
    input  logic [DATALEN-1:0]  cmt_val,
    // captured operand
    output logic [DATALEN-1:0]  val,
    output logic                busy,
    output logic [ROB_W-1:0]    tag
);

    logic [DATALEN-1:0] val_reg,  val_next;
    logic               busy_reg, busy_next;
    logic [ROB_W-1:0]   tag_reg,  tag_next;

    logic               active;
    logic               hit_lookup;
    logic               hit_track;

    assign active = operand_active(need, idx);

    // A commit resolves the operand only when it names the same register and
    // the exact producer tag still recorded as pending; older commits of the
    // same register are stale and ignored.
    assign hit_lookup = cmt_en && (cmt_idx == idx) && rd_busy  && (cmt_tag == rd_tag);
    assign hit_track  = cmt_en && (cmt_idx == idx) && busy_reg && (cmt_tag == tag_reg);

    // Next-state for the captured operand: clear, load with same-cycle bypass,
    // or late bypass while the response is waiting.
    always_comb begin
        val_next  = val_reg;
        busy_next = busy_reg;
        tag_next  = tag_reg;
        if (clear) begin
            val_next  = '0;
            busy_next = 1'b0;
            tag_next  = '0;
        end else if (load) begin
            if (!active) begin
                val_next  = '0;
                busy_next = 1'b0;
                tag_next  = '0;
            end else if (hit_lookup) begin
                val_next  = cmt_val;
                busy_next = 1'b0;
                tag_next  = '0;
            end else begin
                val_next  = rd_val;
                busy_next = rd_busy;
                tag_next  = rd_tag;
            end
        end else if (track && hit_track) begin
            val_next  = cmt_val;
            busy_next = 1'b0;
            tag_next  = '0;
        end
    end

    // Operand register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_reg  <= '0;
            busy_reg <= 1'b0;
            tag_reg  <= '0;
        end else begin
            val_reg  <= val_next;
            busy_reg <= busy_next;
            tag_reg  <= tag_next;
        end
    end

    assign val  = val_reg;
    assign busy = busy_reg;
    assign tag  = tag_reg;

endmodule

// File: rtl/reg_access_ctrl.sv
// Register access controller: accepts a decoder request, reads both source
// operands from the regfile, applies commit bypass, returns operands and then
// renames the destination. Commits pass straight through to the regfile.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int ROB_W = ROBINDEX
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                jump_wrong,

    reg_access_ctrl_if.slave    dec_if,

    // ROB commit
    input  logic                cmt_en,
    input  logic [REGINDEX-1:0] cmt_idx,
    input  logic [ROB_W-1:0]    cmt_tag,
    input  logic [DATALEN-1:0]  cmt_val,

    // regfile read (combinational)
    output logic [REGINDEX-1:0] rf_rd_idx1,
    output logic [REGINDEX-1:0] rf_rd_idx2,
    input  logic [DATALEN-1:0]  rf_rd_val1,
    input  logic [DATALEN-1:0]  rf_rd_val2,
    input  logic                rf_rd_busy1,
    input  logic                rf_rd_busy2,
    input  logic [ROB_W-1:0]    rf_rd_tag1,
    input  logic [ROB_W-1:0]    rf_rd_tag2,

    // regfile writes
    output logic                rf_ren_we,
    output logic [REGINDEX-1:0] rf_ren_idx,
    output logic [ROB_W-1:0]    rf_ren_tag,
    output logic                rf_cmt_we,
    output logic [REGINDEX-1:0] rf_cmt_idx,
    output logic [ROB_W-1:0]    rf_cmt_tag,
    output logic [DATALEN-1:0]  rf_cmt_val,
    output logic                rf_flush
);

    state_t state_reg, state_next;

    // Latched request fields
    logic [REGINDEX-1:0] rs1_reg, rs2_reg, rd_reg;
    logic                need_rs1_reg, need_rs2_reg, have_rd_reg;
    logic [ROB_W-1:0]    rob_tag_reg;

    // Debug-only stall counter (cycles spent in RESP without op_ready)
    logic [STALL_W-1:0]  dbg_stall_cnt_reg, dbg_stall_cnt_next;

    // FSM control strobes
    logic accept;
    logic capture;
    logic track;
    logic flush_now;
    logic ren_fire;
    logic dec_ready_c;
    logic op_valid_c;
    logic rd_drive;

    // Per-operand arrays feeding the two capture instances
    logic [REGINDEX-1:0] opnd_idx     [NUM_OPS];
    logic                opnd_need    [NUM_OPS];
    logic [DATALEN-1:0]  opnd_rd_val  [NUM_OPS];
    logic                opnd_rd_busy [NUM_OPS];
    logic [ROB_W-1:0]    opnd_rd_tag  [NUM_OPS];
    logic [DATALEN-1:0]  opnd_val     [NUM_OPS];
    logic                opnd_busy    [NUM_OPS];
    logic [ROB_W-1:0]    opnd_tag     [NUM_OPS];

    assign opnd_idx[0]     = rs1_reg;
    assign opnd_idx[1]     = rs2_reg;
    assign opnd_need[0]    = need_rs1_reg;
    assign opnd_need[1]    = need_rs2_reg;
    assign opnd_rd_val[0]  = rf_rd_val1;
    assign opnd_rd_val[1]  = rf_rd_val2;
    assign opnd_rd_busy[0] = rf_rd_busy1;
    assign opnd_rd_busy[1] = rf_rd_busy2;
    assign opnd_rd_tag[0]  = rf_rd_tag1;
    assign opnd_rd_tag[1]  = rf_rd_tag2;

    // Commits only take effect (bypass or regfile write) while enabled.
    logic cmt_live;
    assign cmt_live = cmt_en && rdy;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_opnd
            operand_capture #(
                .ROB_W   (ROB_W)
            ) u_operand_capture (
                .clk     (clk),
                .rst     (rst),
                .load    (capture),
                .track   (track),
                .clear   (flush_now),
                .idx     (opnd_idx[gi]),
                .need    (opnd_need[gi]),
                .rd_val  (opnd_rd_val[gi]),
                .rd_busy (opnd_rd_busy[gi]),
                .rd_tag  (opnd_rd_tag[gi]),
                .cmt_en  (cmt_live),
                .cmt_idx (cmt_idx),
                .cmt_tag (cmt_tag),
                .cmt_val (cmt_val),
                .val     (opnd_val[gi]),
                .busy    (opnd_busy[gi]),
                .tag     (opnd_tag[gi])
            );
        end
    endgenerate

    // Next-state and strobe decode. A mispredict wins over everything else,
    // including a same-cycle response handshake, so no rename escapes.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        capture     = 1'b0;
        track       = 1'b0;
        flush_now   = 1'b0;
        ren_fire    = 1'b0;
        dec_ready_c = 1'b0;
        op_valid_c  = 1'b0;
        rd_drive    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                dec_ready_c = !jump_wrong;
                if (rdy) begin
                    if (jump_wrong) begin
                        flush_now  = 1'b1;
                        state_next = ST_FLUSH;
                    end else if (dec_if.dec_valid) begin
                        accept     = 1'b1;
                        state_next = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                rd_drive = 1'b1;
                if (rdy) begin
                    if (jump_wrong) begin
                        flush_now  = 1'b1;
                        state_next = ST_FLUSH;
                    end else begin
                        capture    = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                op_valid_c = !jump_wrong;
                if (rdy) begin
                    if (jump_wrong) begin
                        flush_now  = 1'b1;
                        state_next = ST_FLUSH;
                    end else begin
                        track = 1'b1;
                        if (dec_if.op_ready) begin
                            ren_fire   = have_rd_reg && (rd_reg != '0);
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request field latch on handshake; cleared on flush so nothing lingers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            need_rs1_reg <= 1'b0;
            need_rs2_reg <= 1'b0;
            have_rd_reg  <= 1'b0;
            rob_tag_reg  <= '0;
        end else if (flush_now) begin
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            need_rs1_reg <= 1'b0;
            need_rs2_reg <= 1'b0;
            have_rd_reg  <= 1'b0;
            rob_tag_reg  <= '0;
        end else if (accept) begin
            rs1_reg      <= dec_if.dec_rs1;
            rs2_reg      <= dec_if.dec_rs2;
            rd_reg       <= dec_if.dec_rd;
            need_rs1_reg <= dec_if.dec_need_rs1;
            need_rs2_reg <= dec_if.dec_need_rs2;
            have_rd_reg  <= dec_if.dec_have_rd;
            rob_tag_reg  <= dec_if.dec_rob_tag;
        end
    end

    // Saturating count of cycles the decoder leaves a valid response waiting.
    always_comb begin
        dbg_stall_cnt_next = dbg_stall_cnt_reg;
        if (rdy && (state_reg == ST_RESP) && !jump_wrong && !dec_if.op_ready
                && (dbg_stall_cnt_reg != {STALL_W{1'b1}})) begin
            dbg_stall_cnt_next = dbg_stall_cnt_reg + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_stall_cnt_reg <= '0;
        end else begin
            dbg_stall_cnt_reg <= dbg_stall_cnt_next;
        end
    end

    // Output drive; everything reads zero while reset is held.
    always_comb begin
        dec_if.dec_ready   = rst && dec_ready_c;
        dec_if.op_valid    = rst && op_valid_c;
        dec_if.op_rs1_val  = rst ? opnd_val[0]  : '0;
        dec_if.op_rs2_val  = rst ? opnd_val[1]  : '0;
        dec_if.op_rs1_busy = rst && opnd_busy[0];
        dec_if.op_rs2_busy = rst && opnd_busy[1];
        dec_if.op_rs1_tag  = rst ? opnd_tag[0]  : '0;
        dec_if.op_rs2_tag  = rst ? opnd_tag[1]  : '0;

        rf_rd_idx1 = (rst && rd_drive) ? rs1_reg : '0;
        rf_rd_idx2 = (rst && rd_drive) ? rs2_reg : '0;

        // Rename is issued after the operands were handed over, so an
        // instruction reading its own destination sees the old mapping.
        rf_ren_we  = rst && ren_fire;
        rf_ren_idx = rst ? rd_reg      : '0;
        rf_ren_tag = rst ? rob_tag_reg : '0;

        // Commits are never stalled by the FSM; the regfile orders a
        // same-index rename after the commit.
        rf_cmt_we  = rst && cmt_live;
        rf_cmt_idx = rst ? cmt_idx : '0;
        rf_cmt_tag = rst ? cmt_tag : '0;
        rf_cmt_val = rst ? cmt_val : '0;

        rf_flush   = rst && rdy && (state_reg == ST_FLUSH);
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural regfile read model.
module tb_reg_access_ctrl;

    localparam int ROB_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong;
    logic        cmt_en;
    logic [4:0]  cmt_idx;
    logic [3:0]  cmt_tag;
    logic [31:0] cmt_val;

    logic [4:0]  rf_rd_idx1, rf_rd_idx2;
    logic [31:0] rf_rd_val1, rf_rd_val2;
    logic        rf_rd_busy1, rf_rd_busy2;
    logic [3:0]  rf_rd_tag1, rf_rd_tag2;
    logic        rf_ren_we;
    logic [4:0]  rf_ren_idx;
    logic [3:0]  rf_ren_tag;
    logic        rf_cmt_we;
    logic [4:0]  rf_cmt_idx;
    logic [3:0]  rf_cmt_tag;
    logic [31:0] rf_cmt_val;
    logic        rf_flush;

    // Regfile contents as seen by the lookup port
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rf_rd_val1  = m_val[rf_rd_idx1];
    assign rf_rd_val2  = m_val[rf_rd_idx2];
    assign rf_rd_busy1 = m_busy[rf_rd_idx1];
    assign rf_rd_busy2 = m_busy[rf_rd_idx2];
    assign rf_rd_tag1  = m_tag[rf_rd_idx1];
    assign rf_rd_tag2  = m_tag[rf_rd_idx2];

    reg_access_ctrl_if #(.ROB_W(ROB_W)) dif ();

    reg_access_ctrl #(.ROB_W(ROB_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .jump_wrong  (jump_wrong),
        .dec_if      (dif),
        .cmt_en      (cmt_en),
        .cmt_idx     (cmt_idx),
        .cmt_tag     (cmt_tag),
        .cmt_val     (cmt_val),
        .rf_rd_idx1  (rf_rd_idx1),
        .rf_rd_idx2  (rf_rd_idx2),
        .rf_rd_val1  (rf_rd_val1),
        .rf_rd_val2  (rf_rd_val2),
        .rf_rd_busy1 (rf_rd_busy1),
        .rf_rd_busy2 (rf_rd_busy2),
        .rf_rd_tag1  (rf_rd_tag1),
        .rf_rd_tag2  (rf_rd_tag2),
        .rf_ren_we   (rf_ren_we),
        .rf_ren_idx  (rf_ren_idx),
        .rf_ren_tag  (rf_ren_tag),
        .rf_cmt_we   (rf_cmt_we),
        .rf_cmt_idx  (rf_cmt_idx),
        .rf_cmt_tag  (rf_cmt_tag),
        .rf_cmt_val  (rf_cmt_val),
        .rf_flush    (rf_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v, input logic b, input logic [3:0] t);
        m_val[idx]  = v;
        m_busy[idx] = b;
        m_tag[idx]  = t;
    endtask

    // Present a request in IDLE; returns one tick later with the DUT in LOOKUP.
    task automatic issue(input logic [4:0] rs1, input logic n1, input logic [4:0] rs2,
                         input logic n2, input logic [4:0] rd, input logic hr,
                         input logic [3:0] tag);
        dif.dec_rs1      = rs1;
        dif.dec_need_rs1 = n1;
        dif.dec_rs2      = rs2;
        dif.dec_need_rs2 = n2;
        dif.dec_rd       = rd;
        dif.dec_have_rd  = hr;
        dif.dec_rob_tag  = tag;
        dif.dec_valid    = 1'b1;
        #1;
        chk("accept_ready", {31'd0, dif.dec_ready}, 32'd1);
        tick();
        dif.dec_valid = 1'b0;
        #1;
        chk("lookup_no_valid", {31'd0, dif.op_valid}, 32'd0);
        chk("lookup_idx1", {27'd0, rf_rd_idx1}, {27'd0, rs1});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) set_reg(i, 32'd0, 1'b0, 4'd0);
        rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0;
        cmt_en = 1'b1; cmt_idx = 5'd9; cmt_tag = 4'd1; cmt_val = 32'h1234;
        dif.dec_valid = 1'b0; dif.dec_rs1 = '0; dif.dec_rs2 = '0; dif.dec_rd = '0;
        dif.dec_need_rs1 = 1'b0; dif.dec_need_rs2 = 1'b0; dif.dec_have_rd = 1'b0;
        dif.dec_rob_tag = '0; dif.op_ready = 1'b0;

        // Reset: everything at zero, even with a commit presented
        #2;
        chk("rst_dec_ready", {31'd0, dif.dec_ready}, 32'd0);
        chk("rst_op_valid",  {31'd0, dif.op_valid}, 32'd0);
        chk("rst_cmt_we",    {31'd0, rf_cmt_we}, 32'd0);
        chk("rst_cmt_val",   rf_cmt_val, 32'd0);
        chk("rst_flush",     {31'd0, rf_flush}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("cmt_pass_we",  {31'd0, rf_cmt_we}, 32'd1);
        chk("cmt_pass_idx", {27'd0, rf_cmt_idx}, 32'd9);
        chk("cmt_pass_val", rf_cmt_val, 32'h1234);
        cmt_en = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, dif.dec_ready}, 32'd1);
        $display("TXN reset");

        // No hazard: x5=7, rd=6 tag 3
        set_reg(5, 32'd7, 1'b0, 4'd0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd3);
        tick();
        chk("nh_op_valid", {31'd0, dif.op_valid}, 32'd1);
        chk("nh_rs1_val",  dif.op_rs1_val, 32'd7);
        chk("nh_rs1_busy", {31'd0, dif.op_rs1_busy}, 32'd0);
        chk("nh_ren_early", {31'd0, rf_ren_we}, 32'd0);
        dif.op_ready = 1'b1;
        #1;
        chk("nh_ren_we",  {31'd0, rf_ren_we}, 32'd1);
        chk("nh_ren_idx", {27'd0, rf_ren_idx}, 32'd6);
        chk("nh_ren_tag", {28'd0, rf_ren_tag}, 32'd3);
        tick();
        dif.op_ready = 1'b0;
        #1;
        chk("nh_ren_once", {31'd0, rf_ren_we}, 32'd0);
        chk("nh_idle",     {31'd0, dif.dec_ready}, 32'd1);
        $display("TXN no_hazard");

        // Bypass in LOOKUP: x5 busy tag 2, commit idx5 tag2 val 0x55
        set_reg(5, 32'hdead, 1'b1, 4'd2);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0);
        cmt_en = 1'b1; cmt_idx = 5'd5; cmt_tag = 4'd2; cmt_val = 32'h55;
        tick();
        cmt_en = 1'b0;
        #1;
        chk("byp_rs1_busy", {31'd0, dif.op_rs1_busy}, 32'd0);
        chk("byp_rs1_val",  dif.op_rs1_val, 32'h55);
        dif.op_ready = 1'b1;
        #1;
        chk("byp_no_ren", {31'd0, rf_ren_we}, 32'd0);
        tick();
        dif.op_ready = 1'b0;
        $display("TXN bypass_lookup");

        // Bypass while waiting in RESP on rs2 (x7 busy tag 5)
        set_reg(7, 32'd0, 1'b1, 4'd5);
        issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 4'd0);
        tick();
        chk("rbyp_busy0", {31'd0, dif.op_rs2_busy}, 32'd1);
        chk("rbyp_tag0",  {28'd0, dif.op_rs2_tag}, 32'd5);
        cmt_en = 1'b1; cmt_idx = 5'd7; cmt_tag = 4'd5; cmt_val = 32'h77;
        tick();
        cmt_en = 1'b0;
        #1;
        chk("rbyp_busy1", {31'd0, dif.op_rs2_busy}, 32'd0);
        chk("rbyp_val",   dif.op_rs2_val, 32'h77);
        chk("rbyp_valid", {31'd0, dif.op_valid}, 32'd1);
        dif.op_ready = 1'b1;
        tick();
        dif.op_ready = 1'b0;
        $display("TXN bypass_resp");

        // Stale commit: x5 busy tag 4, commit tag 2 is ignored
        set_reg(5, 32'h99, 1'b1, 4'd4);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0);
        cmt_en = 1'b1; cmt_idx = 5'd5; cmt_tag = 4'd2; cmt_val = 32'h22;
        #1;
        chk("stale_cmt_we", {31'd0, rf_cmt_we}, 32'd1);
        tick();
        cmt_en = 1'b0;
        #1;
        chk("stale_busy", {31'd0, dif.op_rs1_busy}, 32'd1);
        chk("stale_tag",  {28'd0, dif.op_rs1_tag}, 32'd4);
        chk("stale_val",  dif.op_rs1_val, 32'h99);
        dif.op_ready = 1'b1;
        tick();
        dif.op_ready = 1'b0;
        $display("TXN stale_commit");

        // Self-rename: rs1=rd=8, x8 = 0x88
        set_reg(8, 32'h88, 1'b0, 4'd0);
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 4'd6);
        tick();
        chk("self_val",  dif.op_rs1_val, 32'h88);
        chk("self_busy", {31'd0, dif.op_rs1_busy}, 32'd0);
        dif.op_ready = 1'b1;
        #1;
        chk("self_ren_we",  {31'd0, rf_ren_we}, 32'd1);
        chk("self_ren_idx", {27'd0, rf_ren_idx}, 32'd8);
        chk("self_ren_tag", {28'd0, rf_ren_tag}, 32'd6);
        tick();
        dif.op_ready = 1'b0;
        $display("TXN self_rename");

        // x0 and unneeded operands read as ready zero; rd=0 gives no rename
        set_reg(0, 32'hff, 1'b1, 4'd7);
        set_reg(5, 32'h99, 1'b1, 4'd4);
        issue(5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 4'd1);
        tick();
        chk("x0_busy", {31'd0, dif.op_rs1_busy}, 32'd0);
        chk("x0_val",  dif.op_rs1_val, 32'd0);
        chk("nn_busy", {31'd0, dif.op_rs2_busy}, 32'd0);
        chk("nn_tag",  {28'd0, dif.op_rs2_tag}, 32'd0);
        dif.op_ready = 1'b1;
        #1;
        chk("rd0_no_ren", {31'd0, rf_ren_we}, 32'd0);
        tick();
        dif.op_ready = 1'b0;
        $display("TXN zero_operands");

        // Flush in RESP with op_ready=1
        set_reg(5, 32'd7, 1'b0, 4'd0);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd3);
        tick();
        dif.op_ready = 1'b1;
        jump_wrong   = 1'b1;
        #1;
        chk("fl_op_valid", {31'd0, dif.op_valid}, 32'd0);
        chk("fl_no_ren",   {31'd0, rf_ren_we}, 32'd0);
        tick();
        jump_wrong   = 1'b0;
        dif.op_ready = 1'b0;
        #1;
        chk("fl_flush",     {31'd0, rf_flush}, 32'd1);
        chk("fl_not_ready", {31'd0, dif.dec_ready}, 32'd0);
        chk("fl_no_ren2",   {31'd0, rf_ren_we}, 32'd0);
        tick();
        chk("fl_flush_end", {31'd0, rf_flush}, 32'd0);
        chk("fl_ready",     {31'd0, dif.dec_ready}, 32'd1);
        $display("TXN flush");

        // rdy=0 in RESP for 5 cycles: outputs held, no writes
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd3);
        tick();
        rdy = 1'b0;
        dif.op_ready = 1'b1;
        cmt_en = 1'b1; cmt_idx = 5'd3; cmt_tag = 4'd1; cmt_val = 32'h33;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid",  {31'd0, dif.op_valid}, 32'd1);
            chk("hold_val",    dif.op_rs1_val, 32'd7);
            chk("hold_no_ren", {31'd0, rf_ren_we}, 32'd0);
            chk("hold_no_cmt", {31'd0, rf_cmt_we}, 32'd0);
            tick();
        end
        rdy = 1'b1;
        cmt_en = 1'b0;
        #1;
        chk("resume_ren", {31'd0, rf_ren_we}, 32'd1);
        tick();
        dif.op_ready = 1'b0;
        #1;
        chk("resume_idle", {31'd0, dif.dec_ready}, 32'd1);
        $display("TXN rdy_stall");

        // Reset in LOOKUP: outputs drop at once, request abandoned
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd3);
        rst = 1'b0;
        #1;
        chk("mrst_idx1",  {27'd0, rf_rd_idx1}, 32'd0);
        chk("mrst_ready", {31'd0, dif.dec_ready}, 32'd0);
        chk("mrst_valid", {31'd0, dif.op_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        dif.op_ready = 1'b1;
        tick();
        chk("mrst_ready2", {31'd0, dif.dec_ready}, 32'd1);
        chk("mrst_no_ren", {31'd0, rf_ren_we}, 32'd0);
        chk("mrst_val",    dif.op_rs1_val, 32'd0);
        dif.op_ready = 1'b0;
        $display("TXN reset_mid_op");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter ROB_W, default 4, width of a ROB tag.
REQ-002 SHALL have ports `clk` (in, 1), the single clock, and `rst` (in, 1), the asynchronous active-low reset.
REQ-003 SHALL have ports `rdy` (in, 1), global enable, and `jump_wrong` (in, 1), mispredict flush.
REQ-004 SHALL have decoder inputs `dec_valid` (1) and `dec_rs1`/`dec_rs2`/`dec_rd` (5 each).
REQ-005 SHALL have decoder inputs `dec_need_rs1`/`dec_need_rs2`/`dec_have_rd` (1 each) and `dec_rob_tag` (ROB_W), plus output `dec_ready` (1).
REQ-006 SHALL have outputs to decoder `op_valid` (1), `op_rs1_val`/`op_rs2_val` (32), `op_rs1_busy`/`op_rs2_busy` (1) and `op_rs1_tag`/`op_rs2_tag` (ROB_W), plus input `op_ready` (1).
REQ-007 SHALL have ROB commit inputs `cmt_en` (1), `cmt_idx` (5), `cmt_tag` (ROB_W) and `cmt_val` (32).
REQ-008 SHALL have regfile read outputs `rf_rd_idx1`/`rf_rd_idx2` (5), with matching inputs `rf_rd_val1`/`rf_rd_val2` (32), `rf_rd_busy1`/`rf_rd_busy2` (1) and `rf_rd_tag1`/`rf_rd_tag2` (ROB_W), all combinational in the same cycle.
REQ-009 SHALL have regfile write outputs `rf_ren_we`, `rf_ren_idx` (5), `rf_ren_tag` and `rf_cmt_we`, `rf_cmt_idx`, `rf_cmt_tag`, `rf_cmt_val` (32), plus `rf_flush` (1).

Function
REQ-010 SHALL implement FSM IDLE, LOOKUP, RESP, FLUSH; all state advances only when `rdy`=1.
REQ-011 SHALL freeze all state and deassert all `rf_*_we` and `rf_flush` when `rdy`=0.
REQ-012 SHALL drive `dec_ready`=1 only in IDLE; `dec_valid`&`dec_ready` latches the request fields and moves IDLE->LOOKUP.
REQ-013 SHALL in LOOKUP drive `rf_rd_idx1`/`rf_rd_idx2` from the latched rs1/rs2, capture the value/busy/tag results, and move to RESP; lookup latency is exactly 1 cycle after acceptance.
REQ-014 SHALL in RESP hold `op_valid`=1 with stable outputs until `op_ready`=1, then return to IDLE.
REQ-015 SHALL force busy=0, tag=0 and value=0 for any operand whose need bit is 0, or whose index is 0.
REQ-016 SHALL pass every `cmt_en` pulse through to the `rf_cmt_*` outputs in the same cycle, in any state; commits are never stalled.
REQ-017 SHALL apply commit bypass: if a commit arrives in the LOOKUP cycle, or while in RESP, with `cmt_idx` equal to a latched operand index, a captured busy=1 and `cmt_tag` equal to the captured tag, then that operand SHALL become busy=0 with value=`cmt_val`.
REQ-018 SHALL, in the RESP handshake cycle with `dec_have_rd`=1 and rd!=0, pulse `rf_ren_we` for 1 cycle with rd and `dec_rob_tag`, so operands are read before the instruction's own rename.
REQ-019 SHALL, when a commit and a rename target the same index in the same cycle, issue both writes; the regfile orders the rename last.
REQ-020 SHALL on `jump_wrong`=1 enter FLUSH from any state, drop any pending request, deassert `op_valid` and `rf_ren_we`, and pulse `rf_flush` for 1 cycle.
REQ-021 SHALL leave FLUSH for IDLE after 1 cycle; `dec_ready` SHALL be 0 during FLUSH.
REQ-022 SHALL give `jump_wrong` priority over a same-cycle handshake, so no rename is issued in that cycle.
REQ-023 SHALL keep a 16-bit saturating stall counter (RESP with `op_ready`=0) that is visible only as an internal debug wire.

Reset
REQ-024 SHALL on `rst`=0 asynchronously enter IDLE and clear all latched fields and the stall counter.
REQ-025 SHALL during reset drive all outputs to 0; `dec_ready` SHALL read 1 on the first active clock after reset release.
REQ-026 SHALL abandon any in-flight request on reset mid-operation, issuing no rename.

Structure
REQ-027 SHALL take the REGINDEX/ROBINDEX/DATALEN widths and the state encoding from the shared define package.
REQ-028 SHALL have one sub-module, `operand_capture`, instantiated twice (rs1, rs2), holding the value/busy/tag registers and the bypass compare.

Verification
REQ-029 SHALL cover no-hazard: x5=7 not busy, request rs1=5, rd=6, tag=3 -> `op_valid` on cycle 2 with val 7, busy 0, then `rf_ren_we` for x6, tag 3 on handshake.
REQ-030 SHALL cover bypass: x5 busy with tag 2, and a commit of idx 5, tag 2, val 0x55 in the LOOKUP cycle -> rs1 busy 0, val 0x55.
REQ-031 SHALL cover stale commit: x5 busy with tag 4, and a commit of idx 5, tag 2 -> rs1 stays busy with tag 4.
REQ-032 SHALL cover self-rename: rs1=rd=8 with x8 not busy -> operand taken from the old x8, rename issued afterwards.
REQ-033 SHALL cover flush: `jump_wrong` in RESP with `op_ready`=1 -> no `rf_ren_we`, `rf_flush` pulses for 1 cycle, `dec_ready`=1 two cycles later.
REQ-034 SHALL cover reset/rdy: `rst` low in LOOKUP -> all outputs 0 immediately; `rdy`=0 in RESP for 5 cycles -> outputs held and no writes.
